// File: rtl/xup_shift_register_seq_if.sv
// Bundle of data/control/status signals for xup_shift_register_seq.
// master drives load/shift/sequence controls; slave is the register.
interface xup_shift_register_seq_if #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int CNT_W = 4
);
  logic [STEP-1:0]  shift_in;
  logic [WIDTH-1:0] parallel_in;
  logic             load;
  logic             en;
  logic             dir;
  logic [1:0]       mode;
  logic             start;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;
  logic [STEP-1:0]  shift_out;
  logic [WIDTH-1:0] parallel_out;

  modport master (
    output shift_in, parallel_in, load, en, dir,
    output mode, start, count,
    input  busy, done, shift_out, parallel_out
  );

  modport slave (
    input  shift_in, parallel_in, load, en, dir,
    input  mode, start, count,
    output busy, done, shift_out, parallel_out
  );
endinterface

// File: rtl/xup_shift_register_seq.sv
// STEP-bit shift register (logical/rotate/arith/hold) with a counted-shift
// sequencer. Ports: clk, rst_n (async low), bus (slave modport).
module xup_shift_register_seq #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int CNT_W = 4,
  parameter int DELAY = 3
) (
  input logic clk,
  input logic rst_n,
  xup_shift_register_seq_if.slave bus
);

  if (WIDTH < 2 || STEP < 1 || STEP > WIDTH - 1 || DELAY < 0) begin : g_bad
    $error("xup_shift_register_seq: bad parameters");
  end

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] reg_q, reg_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sh;

  // One shift op on the current contents; dir/mode are live inputs.
  always_comb begin
    sh = reg_q;
    unique case (bus.mode)
      2'b00: sh = bus.dir
        ? {reg_q[WIDTH-STEP-1:0], bus.shift_in}
        : {bus.shift_in, reg_q[WIDTH-1:STEP]};
      2'b01: sh = bus.dir
        ? {reg_q[WIDTH-STEP-1:0], reg_q[WIDTH-1 -: STEP]}
        : {reg_q[STEP-1:0], reg_q[WIDTH-1:STEP]};
      2'b10: sh = bus.dir
        ? {reg_q[WIDTH-STEP-1:0], bus.shift_in}
        : {{STEP{reg_q[WIDTH-1]}}, reg_q[WIDTH-1:STEP]};
      default: sh = reg_q;
    endcase
  end

  // load > start (idle) > run step > en (idle)
  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    if (bus.load) begin
      reg_d   = bus.parallel_in;
      rem_d   = '0;
      state_d = IDLE;
    end else if (state_q == IDLE && bus.start) begin
      if (bus.count != '0) begin
        rem_d   = bus.count;
        state_d = RUN;
      end else begin
        done_d = 1'b1;
      end
    end else if (state_q == RUN) begin
      reg_d = sh;
      rem_d = rem_q - 1'b1;
      if (rem_q == CNT_W'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (bus.en) begin
      reg_d = sh;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      reg_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy         = (state_q == RUN);
  assign bus.done         = done_q;
  assign bus.parallel_out = reg_q;
  assign bus.shift_out    = bus.dir
    ? reg_q[WIDTH-1 -: STEP]
    : reg_q[STEP-1:0];

endmodule

// File: tb/tb_xup_shift_register_seq.sv
// Random + directed bench for xup_shift_register_seq, STEP=1 and STEP=4
// instances driven in lockstep against an arithmetic reference model.
module tb_xup_shift_register_seq;
  localparam int W  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       load, en, dir, start;
  logic [1:0] mode;
  logic [7:0] pin;
  logic [3:0] sin;
  logic [3:0] cnt;

  xup_shift_register_seq_if #(.WIDTH(W), .STEP(1), .CNT_W(CW)) a ();
  xup_shift_register_seq_if #(.WIDTH(W), .STEP(4), .CNT_W(CW)) b ();

  assign a.shift_in = sin[0];
  assign b.shift_in = sin;
  assign a.parallel_in = pin;
  assign b.parallel_in = pin;
  assign a.load = load;
  assign b.load = load;
  assign a.en = en;
  assign b.en = en;
  assign a.dir = dir;
  assign b.dir = dir;
  assign a.mode = mode;
  assign b.mode = mode;
  assign a.start = start;
  assign b.start = start;
  assign a.count = cnt;
  assign b.count = cnt;

  xup_shift_register_seq #(.WIDTH(W), .STEP(1), .CNT_W(CW), .DELAY(3))
    u_a (.clk(clk), .rst_n(rst_n), .bus(a.slave));
  xup_shift_register_seq #(.WIDTH(W), .STEP(4), .CNT_W(CW), .DELAY(3))
    u_b (.clk(clk), .rst_n(rst_n), .bus(b.slave));

  int errs = 0;
  int checks = 0;

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model, index 0 -> STEP=1, index 1 -> STEP=4
  int st[2] = '{1, 4};
  int mr[2];
  int mrem[2];
  bit mb[2];
  bit md[2];

  function automatic int op(int r, bit d, int m, int si, int s);
    int msk = (1 << s) - 1;
    int f   = si & msk;
    int res = r;
    case (m)
      0: res = d ? ((r << s) | f) : ((r >> s) | (f << (W - s)));
      1: res = d ? ((r << s) | (r >> (W - s))) : ((r >> s) | (r << (W - s)));
      2: res = d ? ((r << s) | f)
                 : ((r >> s) | (((r >> (W-1)) & 1) != 0 ? (255 << (W - s)) : 0));
      default: res = r;
    endcase
    return res & 255;
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit nd = 1'b0;
      if (load) begin
        mr[i] = pin; mb[i] = 1'b0; mrem[i] = 0;
      end else if (!mb[i] && start) begin
        if (cnt != 0) begin mrem[i] = cnt; mb[i] = 1'b1; end
        else nd = 1'b1;
      end else if (mb[i]) begin
        mr[i] = op(mr[i], dir, mode, sin, st[i]);
        mrem[i]--;
        if (mrem[i] == 0) begin mb[i] = 1'b0; nd = 1'b1; end
      end else if (en) begin
        mr[i] = op(mr[i], dir, mode, sin, st[i]);
      end
      md[i] = nd;
    end
  endtask

  function automatic int exp_so(int i);
    return dir ? (mr[i] >> (W - st[i])) : (mr[i] & ((1 << st[i]) - 1));
  endfunction

  task automatic check_outs(string tag);
    chk({tag, ":a.po"}, a.parallel_out, mr[0]);
    chk({tag, ":a.busy"}, a.busy, mb[0]);
    chk({tag, ":a.done"}, a.done, md[0]);
    chk({tag, ":a.so"}, a.shift_out, exp_so(0));
    chk({tag, ":b.po"}, b.parallel_out, mr[1]);
    chk({tag, ":b.busy"}, b.busy, mb[1]);
    chk({tag, ":b.done"}, b.done, md[1]);
    chk({tag, ":b.so"}, b.shift_out, exp_so(1));
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outs(tag);
  endtask

  task automatic quiet();
    load = 0; en = 0; start = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mr[i] = 0; mrem[i] = 0; mb[i] = 0; md[i] = 0;
    end
  endtask

  initial begin
    quiet();
    dir = 0; mode = 0; pin = 0; sin = 0; cnt = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outs("reset");
    rst_n = 1'b1;

    // rotate-left sequence of 3 from 0xA5
    pin = 8'hA5; load = 1; step("ldA5"); load = 0;
    mode = 2'b01; dir = 1; start = 1; cnt = 3;
    step("E0"); start = 0;
    chk("rot.busyE0", a.busy, 1);
    step("E1");
    step("E2");
    chk("rot.busyE2", a.busy, 1);
    step("E3");
    chk("rot.po", a.parallel_out, 8'h2D);
    chk("rot.done", a.done, 1);
    chk("rot.busyE3", a.busy, 0);
    step("E4");
    chk("rot.hold", a.parallel_out, 8'h2D);
    chk("rot.done1", a.done, 0);

    // arithmetic right
    pin = 8'h90; load = 1; step("ld90"); load = 0;
    mode = 2'b10; dir = 0; en = 1;
    step("ar1"); chk("ar.C8", a.parallel_out, 8'hC8);
    step("ar2"); chk("ar.E4", a.parallel_out, 8'hE4);
    en = 0;

    // logical left fill with ones
    pin = 8'h0F; load = 1; step("ld0F"); load = 0;
    mode = 2'b00; dir = 1; sin = 4'h1; en = 1;
    step("ll1"); chk("ll.1F", a.parallel_out, 8'h1F); chk("ll.so1", a.shift_out, 0);
    step("ll2"); chk("ll.3F", a.parallel_out, 8'h3F);
    step("ll3"); chk("ll.7F", a.parallel_out, 8'h7F); chk("ll.so3", a.shift_out, 0);
    step("ll4"); chk("ll.FF", a.parallel_out, 8'hFF); chk("ll.so4", a.shift_out, 1);
    en = 0;

    // zero-length sequence
    start = 1; cnt = 0; step("z0"); start = 0;
    chk("z.done", a.done, 1); chk("z.busy", a.busy, 0);
    chk("z.po", a.parallel_out, 8'hFF);
    step("z1"); chk("z.done1", a.done, 0);

    // start while busy ignored
    mode = 2'b01; dir = 0; start = 1; cnt = 5; step("s0"); start = 0;
    step("s1");
    start = 1; cnt = 2; step("s2"); start = 0;
    step("s3"); step("s4");
    chk("ign.busy", a.busy, 1);
    step("s5");
    chk("ign.done", a.done, 1);

    // load aborts sequence
    start = 1; cnt = 5; step("l0"); start = 0;
    step("l1"); step("l2");
    pin = 8'h55; load = 1; step("l3"); load = 0;
    chk("ab.po", a.parallel_out, 8'h55); chk("ab.busy", a.busy, 0);
    chk("ab.done", a.done, 0);
    step("l4"); chk("ab.done1", a.done, 0);

    // STEP=4 rotate right by one nibble
    pin = 8'h3C; load = 1; step("ld3C"); load = 0;
    mode = 2'b01; dir = 0; start = 1; cnt = 1; step("n0"); start = 0;
    step("n1");
    chk("n.po", b.parallel_out, 8'hC3); chk("n.so", b.shift_out, 4'h3);
    chk("n.done", b.done, 1);

    // async reset mid-sequence
    start = 1; cnt = 9; step("r0"); start = 0;
    step("r1"); step("r2");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst.po", a.parallel_out, 0); chk("rst.busy", a.busy, 0);
    chk("rst.done", a.done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_outs("rstrel");
    step("r3"); step("r4");
    chk("rst.nodone", a.done, 0);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      load  = ($urandom_range(0, 15) == 0);
      start = ($urandom_range(0, 5) == 0);
      en    = $urandom_range(0, 1);
      dir   = $urandom_range(0, 1);
      mode  = 2'($urandom_range(0, 3));
      pin   = 8'($urandom);
      sin   = 4'($urandom);
      cnt   = 4'($urandom_range(0, 6));
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
